codes_enc_16to4_stream: RTL and testbench



---
 rtl/codes_enc_16to4_stream_if.sv | 22 ++
 rtl/codes_enc_16to4_stream.sv | 97 +++++++++
 tb/tb_codes_enc_16to4_stream.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/codes_enc_16to4_stream_if.sv
// Stream bundle for the 16-to-4 encoder: a 16-bit vector in, 4-bit indices out.
// The master is the producer/consumer side. The slave is the encoder.
interface codes_enc_16to4_stream_if;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] in_;
  logic        out_val;
  logic        out_rdy;
  logic [3:0]  out;
  logic        out_last;
  logic        out_zero;

  modport master (
    output in_val, in_, out_rdy,
    input  in_rdy, out_val, out, out_last, out_zero
  );

  modport slave (
    input  in_val, in_, out_rdy,
    output in_rdy, out_val, out, out_last, out_zero
  );
endinterface

// File: rtl/codes_enc_16to4_stream.sv
// Sequential 16-to-4 encoder: emits the index of every set bit of an accepted
// vector, lowest first, one per transfer; an all-zero vector yields one zero beat.
module codes_enc_16to4_stream (
  input  logic                            clk,
  input  logic                            reset,
  codes_enc_16to4_stream_if.slave         bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_next;
  logic [15:0] pending, pending_next;
  logic        zero_flag, zero_flag_next;

  logic [15:0] pending_rest;
  logic [3:0]  low_index;
  logic        last_beat;
  logic        out_fire;
  logic        in_fire;

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Subtracting one flips the lowest set bit and everything below it, so the
  // AND clears exactly the bit being emitted; zero rest means single bit left.
  assign pending_rest = pending & (pending - 16'd1);
  assign low_index    = lowest_index(pending);
  assign last_beat    = zero_flag || (pending_rest == 16'd0);

  // Outputs come from registered state only; no in_ -> out path.
  assign bus.out_val  = (state == BUSY);
  assign bus.out      = (state == BUSY && !zero_flag) ? low_index : 4'd0;
  assign bus.out_last = (state == BUSY) && last_beat;
  assign bus.out_zero = (state == BUSY) && zero_flag;

  // in_rdy looks through to out_rdy so a new vector can follow the final beat
  // with no bubble; it is forced low while reset is held.
  assign bus.in_rdy = !reset &&
                      ((state == IDLE) || (bus.out_rdy && last_beat));

  assign out_fire = bus.out_val && bus.out_rdy;
  assign in_fire  = bus.in_val && bus.in_rdy;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    state_next     = state;
    pending_next   = pending;
    zero_flag_next = zero_flag;

    unique case (state)
      IDLE: begin
        if (in_fire) begin
          pending_next   = bus.in_;
          zero_flag_next = (bus.in_ == 16'd0);
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (out_fire) begin
          pending_next = pending_rest;
          if (last_beat) begin
            if (in_fire) begin
              pending_next   = bus.in_;
              zero_flag_next = (bus.in_ == 16'd0);
            end else begin
              zero_flag_next = 1'b0;
              state_next     = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values sampled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 16'd0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      zero_flag <= zero_flag_next;
    end
  end

endmodule

// File: tb/tb_codes_enc_16to4_stream.sv
// Directed bench for codes_enc_16to4_stream: hand-computed index sequences,
// backpressure, back-to-back vectors and asynchronous reset mid-vector.
module tb_codes_enc_16to4_stream;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  codes_enc_16to4_stream_if bus ();

  codes_enc_16to4_stream dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [3:0] idx, input logic last, input logic zero);
    check({tag, ".val"},  32'(bus.out_val),  32'd1);
    check({tag, ".out"},  32'(bus.out),      32'(idx));
    check({tag, ".last"}, 32'(bus.out_last), 32'(last));
    check({tag, ".zero"}, 32'(bus.out_zero), 32'(zero));
  endtask

  task automatic accept(input string tag, input logic [15:0] vec);
    bus.in_val = 1'b1;
    bus.in_    = vec;
    #1;
    check({tag, ".in_rdy"}, 32'(bus.in_rdy), 32'd1);
    step();
    bus.in_val = 1'b0;
    bus.in_    = 16'hDEAD;
  endtask

  task automatic idle_check(input string tag);
    check({tag, ".idle_val"}, 32'(bus.out_val), 32'd0);
    check({tag, ".idle_rdy"}, 32'(bus.in_rdy),  32'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_     = 16'h0000;
    bus.out_rdy = 1'b1;

    // Reset state
    #12;
    check("rst.out_val",  32'(bus.out_val),  32'd0);
    check("rst.in_rdy",   32'(bus.in_rdy),   32'd0);
    check("rst.out",      32'(bus.out),      32'd0);
    check("rst.out_last", 32'(bus.out_last), 32'd0);
    check("rst.out_zero", 32'(bus.out_zero), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("rst.release_rdy", 32'(bus.in_rdy), 32'd1);
    step();

    // Single bit: 0x0100 -> index 8
    accept("v0100", 16'h0100);
    beat("v0100.b0", 4'd8, 1'b1, 1'b0);
    check("v0100.b0.in_rdy", 32'(bus.in_rdy), 32'd1);
    step();
    idle_check("v0100");

    // Three bits: 0x8005 -> 0, 2, 15
    accept("v8005", 16'h8005);
    beat("v8005.b0", 4'd0, 1'b0, 1'b0);
    check("v8005.b0.in_rdy", 32'(bus.in_rdy), 32'd0);
    step();
    beat("v8005.b1", 4'd2, 1'b0, 1'b0);
    check("v8005.b1.in_rdy", 32'(bus.in_rdy), 32'd0);
    step();
    beat("v8005.b2", 4'd15, 1'b1, 1'b0);
    step();
    idle_check("v8005");

    // All-zero vector -> one zero beat
    accept("v0000", 16'h0000);
    beat("v0000.b0", 4'd0, 1'b1, 1'b1);
    step();
    idle_check("v0000");

    // Backpressure: 0x0012 held for 3 cycles, then 1, 4
    bus.out_rdy = 1'b0;
    accept("v0012", 16'h0012);
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("v0012.stall%0d", i), 4'd1, 1'b0, 1'b0);
      check($sformatf("v0012.stall%0d.in_rdy", i), 32'(bus.in_rdy), 32'd0);
      step();
    end
    bus.out_rdy = 1'b1;
    #1;
    beat("v0012.b0", 4'd1, 1'b0, 1'b0);
    step();
    beat("v0012.b1", 4'd4, 1'b1, 1'b0);
    step();
    idle_check("v0012");

    // Back-to-back: 0x0003 then 0x8000 with in_val held high
    bus.in_val = 1'b1;
    bus.in_    = 16'h0003;
    #1;
    check("b2b.first.in_rdy", 32'(bus.in_rdy), 32'd1);
    step();
    bus.in_ = 16'h8000;
    #1;
    beat("b2b.b0", 4'd0, 1'b0, 1'b0);
    check("b2b.b0.in_rdy", 32'(bus.in_rdy), 32'd0);
    step();
    beat("b2b.b1", 4'd1, 1'b1, 1'b0);
    check("b2b.b1.in_rdy", 32'(bus.in_rdy), 32'd1);
    step();
    bus.in_val = 1'b0;
    bus.in_    = 16'h0000;
    #1;
    beat("b2b.b2", 4'd15, 1'b1, 1'b0);
    step();
    idle_check("b2b");

    // 0xFFFF, reset asserted after beat 5 consumed
    accept("vffff", 16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      beat($sformatf("vffff.b%0d", i), 4'(i), 1'b0, 1'b0);
      step();
    end
    beat("vffff.b6", 4'd6, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async.out_val",  32'(bus.out_val),  32'd0);
    check("async.in_rdy",   32'(bus.in_rdy),   32'd0);
    check("async.out",      32'(bus.out),      32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async.release_rdy", 32'(bus.in_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("async.stale%0d", i), 32'(bus.out_val), 32'd0);
    end

    // Encoder still works after the mid-vector reset
    accept("v0001", 16'h0001);
    beat("v0001.b0", 4'd0, 1'b1, 1'b0);
    step();
    idle_check("v0001");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
